mdr_store_buffer: RTL

- Write-direction counterpart of the memory data register path in the 16-bit accumulator processor.
- The datapath pushes store requests (address + data) into a small FIFO; the block drains them to data memory over a write/acknowledge handshake.
- Loads issued while stores are pending can snoop the buffer and receive forwarded data.
- Sits between the control unit's store step and the memory write port.

---
 rtl/mdr_store_buffer_if.sv | 31 +++
 rtl/mdr_store_buffer.sv | 105 ++++++++++
 2 files changed

// File: rtl/mdr_store_buffer_if.sv
// mdr_store_buffer_if: store-push, memory-write and load-snoop signals of the store buffer.
//   st_valid/st_addr/st_data/st_ready : datapath store push handshake
//   mem_addr/mem_wdata/mem_we/mem_ack : memory write request and acknowledge
//   ld_addr/ld_hit/ld_data            : load snoop and forwarded data
// master = datapath/memory side, slave = the store buffer.
interface mdr_store_buffer_if #(
    parameter int AW = 16,
    parameter int DW = 16
) ();
    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          st_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_ack;
    logic [AW-1:0] ld_addr;
    logic          ld_hit;
    logic [DW-1:0] ld_data;

    modport master (
        output st_valid, st_addr, st_data, mem_ack, ld_addr,
        input  st_ready, mem_addr, mem_wdata, mem_we, ld_hit, ld_data
    );

    modport slave (
        input  st_valid, st_addr, st_data, mem_ack, ld_addr,
        output st_ready, mem_addr, mem_wdata, mem_we, ld_hit, ld_data
    );
endinterface

// File: rtl/mdr_store_buffer.sv
// mdr_store_buffer: FIFO of pending stores drained to data memory, with load forwarding.
//   clk   : system clock, all state on posedge
//   reset : synchronous active-low reset
//   bus   : slave side of mdr_store_buffer_if (store push, memory write, load snoop)
//   empty : no pending or in-flight stores
//   count : occupied entries, in-flight head included
module mdr_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    mdr_store_buffer_if.slave    bus,
    output logic                 empty,
    output logic [2:0]           count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic          push, pop, hit;
    logic [DW-1:0] fwd;

    assign bus.st_ready  = (cnt_q != CW'(DEPTH));
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.ld_hit    = hit;
    assign bus.ld_data   = fwd;
    assign empty         = (cnt_q == '0);
    assign count         = 3'(cnt_q);

    always_comb begin
        push        = bus.st_valid && bus.st_ready;
        pop         = (state_q == WRITE) && bus.mem_ack;
        state_d     = state_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cnt_d       = cnt_q + CW'(push) - CW'(pop);
        wr_ptr_d    = wr_ptr_q + PW'(push);
        rd_ptr_d    = rd_ptr_q + PW'(pop);
        if (state_q == IDLE && cnt_q != '0) begin
            state_d     = WRITE;
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_q[rd_ptr_q];
            mem_wdata_d = data_q[rd_ptr_q];
        end else if (pop) begin
            state_d  = (cnt_d != '0) ? WRITE : IDLE;
            mem_we_d = (cnt_d != '0);
            // With one entry left the next head is the store arriving this very edge
            mem_addr_d  = (cnt_d == '0) ? mem_addr_q : (cnt_q == CW'(1)) ? bus.st_addr : addr_q[rd_ptr_d];
            mem_wdata_d = (cnt_d == '0) ? mem_wdata_q : (cnt_q == CW'(1)) ? bus.st_data : data_q[rd_ptr_d];
        end
    end

    // Walk oldest to youngest so the last match wins
    always_comb begin
        hit = 1'b0;
        fwd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < cnt_q && addr_q[rd_ptr_q + PW'(i)] == bus.ld_addr) begin
                hit = 1'b1;
                fwd = data_q[rd_ptr_q + PW'(i)];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= bus.st_addr;
            data_q[wr_ptr_q] <= bus.st_data;
        end
    end
endmodule
